// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder.
//   word_t     : 32-bit data/address word
//   bus_cmd_e  : processor bus command encoding (value 3 is illegal)
//   wbuf_t     : posted-write buffer entry (valid, word offset, data)
//   in_window(): byte address falls inside [base, base + span_bytes)
package dmem_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  localparam int unsigned WORD_BYTES = 4;

  typedef struct packed {
    logic  valid;
    word_t widx;   // word offset from BASE_ADDR
    word_t data;
  } wbuf_t;

  // 33-bit span so a full 4 GiB-adjacent window cannot overflow the compare.
  function automatic logic in_window(input word_t addr, input word_t base,
                                     input logic [32:0] span_bytes);
    word_t off;
    off = addr - base;
    return (addr >= base) && ({1'b0, off} < span_bytes);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Processor <-> data-memory bus.
//   proc2Dmem_command : BUS_NONE/BUS_LOAD/BUS_STORE (3 illegal)
//   proc2Dmem_addr    : byte address
//   proc2Dmem_data    : store data
//   mem2proc_data     : load data, valid in the same cycle as BUS_LOAD
interface dmem_responder_if;
  import dmem_pkg::*;

  logic [1:0] proc2Dmem_command;
  word_t      proc2Dmem_addr;
  word_t      proc2Dmem_data;
  word_t      mem2proc_data;

  modport master (
    output proc2Dmem_command,
    output proc2Dmem_addr,
    output proc2Dmem_data,
    input  mem2proc_data
  );

  modport slave (
    input  proc2Dmem_command,
    input  proc2Dmem_addr,
    input  proc2Dmem_data,
    output mem2proc_data
  );

endinterface

// File: rtl/dmem_array.sv
// DEPTH_WORDS x 32 storage: one asynchronous read port, one synchronous
// write port. Contents are intentionally not reset.
//   clk           : write clock
//   we/waddr/wdata: write port
//   raddr/rdata   : combinational read port
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  word_t                          wdata,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output word_t                          rdata
);

  word_t mem [DEPTH_WORDS];

  // Synchronous write
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read
  assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_responder.sv
// Zero-wait-state data memory with a 1-entry posted-write buffer.
// Loads return combinationally (buffer forwarding on a word-address hit);
// stores post into the buffer and commit to the array on a later edge.
// A debug write port preloads the array and has priority over commits.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   bus           : dmem_responder_if.slave processor bus
//   dbg_wr_en/dbg_addr/dbg_wdata : preload write port
//   wbuf_pending  : buffer holds an uncommitted store
//   dmem_err      : sticky access-error flag
//   ld_count/st_count : non-error load/store counters (only with DMEM_STATS_EN)
// Build option: define DMEM_STATS_EN to add the saturating counters.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter word_t       BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  input  logic              dbg_wr_en,
  input  word_t             dbg_addr,
  input  word_t             dbg_wdata,
  output logic              wbuf_pending,
  output logic              dmem_err
`ifdef DMEM_STATS_EN
  ,
  output word_t             ld_count,
  output word_t             st_count
`endif
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'(WORD_BYTES);

  // Address decode
  word_t bus_widx;
  word_t dbg_widx;
  logic  bus_addr_ok;
  logic  dbg_addr_ok;
  logic  cmd_load;
  logic  cmd_store;
  logic  cmd_bad;
  logic  acc_err;
  logic  ld_ok;
  logic  st_ok;
  logic  dbg_ok;

  assign bus_widx    = (bus.proc2Dmem_addr - BASE_ADDR) >> 2;
  assign dbg_widx    = (dbg_addr - BASE_ADDR) >> 2;
  assign bus_addr_ok = (bus.proc2Dmem_addr[1:0] == 2'b00) &&
                       in_window(bus.proc2Dmem_addr, BASE_ADDR, SPAN_BYTES);
  assign dbg_addr_ok = (dbg_addr[1:0] == 2'b00) &&
                       in_window(dbg_addr, BASE_ADDR, SPAN_BYTES);

  assign cmd_load  = (bus.proc2Dmem_command == BUS_LOAD);
  assign cmd_store = (bus.proc2Dmem_command == BUS_STORE);
  assign cmd_bad   = (bus.proc2Dmem_command == 2'd3);
  assign acc_err   = cmd_bad || ((cmd_load || cmd_store) && !bus_addr_ok);
  assign ld_ok     = cmd_load && bus_addr_ok;
  assign st_ok     = cmd_store && bus_addr_ok;
  assign dbg_ok    = dbg_wr_en && dbg_addr_ok;

  // State
  wbuf_t wbuf_q, wbuf_d;
  logic  dmem_err_q, dmem_err_d;

  // Array port
  logic        arr_we;
  logic [AW-1:0] arr_widx;
  word_t       arr_wdata;
  word_t       arr_rdata;
  logic        st_hit;
  word_t       rd_data;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_widx),
    .wdata (arr_wdata),
    .raddr (AW'(bus_widx)),
    .rdata (arr_rdata)
  );

  // Write-buffer update and array write-port arbitration
  always_comb begin
    wbuf_d    = wbuf_q;
    arr_we    = 1'b0;
    arr_widx  = '0;
    arr_wdata = '0;
    st_hit    = wbuf_q.valid && st_ok && (bus_widx == wbuf_q.widx);

    if (dbg_ok) begin
      // Debug write owns the array port; buffer holds, but tracks a hit.
      arr_we    = !rst;
      arr_widx  = AW'(dbg_widx);
      arr_wdata = dbg_wdata;
      if (wbuf_q.valid && (dbg_widx == wbuf_q.widx)) begin
        wbuf_d.data = dbg_wdata;
      end
    end else if (wbuf_q.valid && !st_hit) begin
      // Commit unless a same-word store is coalescing into the entry.
      arr_we       = !rst;
      arr_widx     = AW'(wbuf_q.widx);
      arr_wdata    = wbuf_q.data;
      wbuf_d.valid = 1'b0;
    end

    // A new store always lands in the buffer. If a debug write blocked the
    // commit of a different word, that older entry is displaced; the debug
    // port is only meant for use while the bus is quiet.
    if (st_ok) begin
      wbuf_d.valid = 1'b1;
      wbuf_d.widx  = bus_widx;
      wbuf_d.data  = bus.proc2Dmem_data;
    end
  end

  // Sticky error
  always_comb begin
    dmem_err_d = dmem_err_q || acc_err;
  end

  // Load data: buffer forwarding on a word hit, zero otherwise
  always_comb begin
    rd_data = '0;
    if (!rst && ld_ok) begin
      if (wbuf_q.valid && (bus_widx == wbuf_q.widx)) begin
        rd_data = wbuf_q.data;
      end else begin
        rd_data = arr_rdata;
      end
    end
  end

  assign bus.mem2proc_data = rd_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbuf_q     <= '0;
      dmem_err_q <= 1'b0;
    end else begin
      wbuf_q     <= wbuf_d;
      dmem_err_q <= dmem_err_d;
    end
  end

  assign wbuf_pending = wbuf_q.valid;
  assign dmem_err     = dmem_err_q;

`ifdef DMEM_STATS_EN
  word_t ld_count_q, ld_count_d;
  word_t st_count_q, st_count_d;

  // Saturating access counters
  always_comb begin
    ld_count_d = ld_count_q;
    st_count_d = st_count_q;
    if (ld_ok && (ld_count_q != 32'hFFFF_FFFF)) begin
      ld_count_d = ld_count_q + 32'd1;
    end
    if (st_ok && (st_count_q != 32'hFFFF_FFFF)) begin
      st_count_d = st_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_count_q <= '0;
      st_count_q <= '0;
    end else begin
      ld_count_q <= ld_count_d;
      st_count_q <= st_count_d;
    end
  end

  assign ld_count = ld_count_q;
  assign st_count = st_count_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a reference memory model drives a
// scoreboard queue of expected load data; each scenario task checks status
// flags and array contents inline.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 1024;
  localparam word_t       BASE  = 32'h0000_0000;

  logic  clk = 1'b0;
  logic  rst;
  logic  dbg_wr_en;
  word_t dbg_addr;
  word_t dbg_wdata;
  logic  wbuf_pending;
  logic  dmem_err;
`ifdef DMEM_STATS_EN
  word_t ld_count;
  word_t st_count;
`endif

  int passed = 0;
  int total  = 0;

  word_t exp_q[$];
  word_t model_mem [word_t];

  dmem_responder_if bus();

  dmem_responder #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .dbg_wr_en    (dbg_wr_en),
    .dbg_addr     (dbg_addr),
    .dbg_wdata    (dbg_wdata),
    .wbuf_pending (wbuf_pending),
    .dmem_err     (dmem_err)
`ifdef DMEM_STATS_EN
    ,
    .ld_count     (ld_count),
    .st_count     (st_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic addr_bad(input word_t addr);
    return (addr[1:0] != 2'b00) || ((addr - BASE) >= 32'(4 * DEPTH));
  endfunction

  function automatic logic exp_err(input logic [1:0] cmd, input word_t addr);
    if (cmd == 2'd3) return 1'b1;
    if (cmd == 2'd0) return 1'b0;
    return addr_bad(addr);
  endfunction

  // One bus cycle: drive at negedge, score mem2proc_data before the edge.
  task automatic do_op(input logic [1:0] cmd, input word_t addr,
                       input word_t data, input string tag);
    word_t exp;
    word_t got;
    logic  err;
    @(negedge clk);
    bus.proc2Dmem_command = cmd;
    bus.proc2Dmem_addr    = addr;
    bus.proc2Dmem_data    = data;
    err = exp_err(cmd, addr);
    if ((cmd == 2'd1) && !err && model_mem.exists(addr)) exp = model_mem[addr];
    else exp = 32'h0;
    exp_q.push_back(exp);
    #1;
    got = bus.mem2proc_data;
    exp = exp_q.pop_front();
    total++;
    if (got !== exp) $display("FAIL %s rdata: got %h want %h", tag, got, exp);
    else passed++;
    if ((cmd == 2'd2) && !err) model_mem[addr] = data;
    @(posedge clk);
    #1;
    bus.proc2Dmem_command = 2'd0;
  endtask

  task automatic dbg_write(input word_t addr, input word_t data);
    @(negedge clk);
    dbg_wr_en = 1'b1;
    dbg_addr  = addr;
    dbg_wdata = data;
    @(posedge clk);
    #1;
    dbg_wr_en = 1'b0;
    if (!addr_bad(addr)) model_mem[addr] = data;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dbg_wr_en = 1'b0;
    dbg_addr  = '0;
    dbg_wdata = '0;
    bus.proc2Dmem_command = 2'd1;
    bus.proc2Dmem_addr    = 32'h0;
    bus.proc2Dmem_data    = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (wbuf_pending !== 1'b0) $display("FAIL reset_pending: got %b want 0", wbuf_pending);
    else passed++;
    total++;
    if (dmem_err !== 1'b0) $display("FAIL reset_err: got %b want 0", dmem_err);
    else passed++;
    total++;
    if (bus.mem2proc_data !== 32'h0) $display("FAIL reset_rdata: got %h want 0", bus.mem2proc_data);
    else passed++;
`ifdef DMEM_STATS_EN
    total++;
    if (ld_count !== 32'h0 || st_count !== 32'h0)
      $display("FAIL reset_counts: got %0d/%0d want 0/0", ld_count, st_count);
    else passed++;
`endif
    rst = 1'b0;
    bus.proc2Dmem_command = 2'd0;
  endtask

  task automatic test_preload_load();
    dbg_write(32'h100, 32'hDEAD_BEEF);
    do_op(2'd1, 32'h100, 32'h0, "ld_preload_100");
    do_op(2'd0, 32'h100, 32'h0, "none_rdata");
    total++;
    if (dmem_err !== 1'b0) $display("FAIL preload_err: got %b want 0", dmem_err);
    else passed++;
  endtask

  task automatic test_store_forward();
    dbg_write(32'h40, 32'h0);
    do_op(2'd2, 32'h40, 32'h1234_5678, "st_40_rdata");
    total++;
    if (wbuf_pending !== 1'b1) $display("FAIL fwd_pending: got %b want 1", wbuf_pending);
    else passed++;
    total++;
    if (dut.u_array.mem[16] !== 32'h0) $display("FAIL fwd_array_early: got %h want 0", dut.u_array.mem[16]);
    else passed++;
    do_op(2'd1, 32'h40, 32'h0, "ld_fwd_40");
    @(posedge clk);
    #1;
    total++;
    if (wbuf_pending !== 1'b0) $display("FAIL fwd_drained: got %b want 0", wbuf_pending);
    else passed++;
    total++;
    if (dut.u_array.mem[16] !== 32'h1234_5678)
      $display("FAIL fwd_array_commit: got %h want 12345678", dut.u_array.mem[16]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    do_op(2'd2, 32'h40, 32'h1, "b2b_st1");
    do_op(2'd2, 32'h40, 32'h2, "b2b_st2");
    total++;
    if (dut.u_array.mem[16] !== 32'h1234_5678)
      $display("FAIL b2b_coalesce: got %h want 12345678", dut.u_array.mem[16]);
    else passed++;
    do_op(2'd2, 32'h44, 32'h3, "b2b_st44");
    total++;
    if (dut.u_array.mem[16] !== 32'h2) $display("FAIL b2b_commit40: got %h want 2", dut.u_array.mem[16]);
    else passed++;
    total++;
    if (wbuf_pending !== 1'b1) $display("FAIL b2b_pending44: got %b want 1", wbuf_pending);
    else passed++;
    do_op(2'd1, 32'h40, 32'h0, "b2b_ld40");
    do_op(2'd1, 32'h44, 32'h0, "b2b_ld44");
    // Forwarding of a coalesced value
    dbg_write(32'h48, 32'h0000_AAAA);
    do_op(2'd2, 32'h48, 32'h7, "b2b_st48a");
    do_op(2'd2, 32'h48, 32'h2, "b2b_st48b");
    do_op(2'd1, 32'h48, 32'h0, "b2b_ld48_fwd");
  endtask

  task automatic test_dbg_rules();
    dbg_write(32'h0, 32'h0BAD_0000);
    dbg_write(32'h1000, 32'hFFFF_FFFF);
    dbg_write(32'h102, 32'hFFFF_FFFF);
    total++;
    if (dut.u_array.mem[0] !== 32'h0BAD_0000) $display("FAIL dbg_oor: got %h want 0bad0000", dut.u_array.mem[0]);
    else passed++;
    total++;
    if (dut.u_array.mem[64] !== 32'hDEAD_BEEF) $display("FAIL dbg_misal: got %h want deadbeef", dut.u_array.mem[64]);
    else passed++;
    total++;
    if (dmem_err !== 1'b0) $display("FAIL dbg_no_err: got %b want 0", dmem_err);
    else passed++;
    do_op(2'd2, 32'h60, 32'd11, "dbg_st60");
    dbg_write(32'h60, 32'd22);
    total++;
    if (wbuf_pending !== 1'b1) $display("FAIL dbg_hold: got %b want 1", wbuf_pending);
    else passed++;
    total++;
    if (dut.u_array.mem[24] !== 32'd22) $display("FAIL dbg_array60: got %h want 16", dut.u_array.mem[24]);
    else passed++;
    do_op(2'd1, 32'h60, 32'h0, "dbg_ld60");
  endtask

  task automatic test_errors();
    do_op(2'd1, 32'h102, 32'h0, "err_ld_misal");
    total++;
    if (dmem_err !== 1'b1) $display("FAIL err_set: got %b want 1", dmem_err);
    else passed++;
    do_op(2'd2, 32'(4 * DEPTH), 32'h5555_5555, "err_st_oor");
    total++;
    if (dut.u_array.mem[0] !== 32'h0BAD_0000) $display("FAIL err_array: got %h want 0bad0000", dut.u_array.mem[0]);
    else passed++;
    total++;
    if (wbuf_pending !== 1'b0) $display("FAIL err_drop: got %b want 0", wbuf_pending);
    else passed++;
    do_op(2'd3, 32'h100, 32'h0, "err_cmd3");
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dmem_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", dmem_err);
    else passed++;
  endtask

  task automatic test_reset_mid();
    dbg_write(32'h80, 32'h0000_A5A5);
    do_op(2'd2, 32'h80, 32'd5, "rst_st80");
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (wbuf_pending !== 1'b0) $display("FAIL rst_mid_pending: got %b want 0", wbuf_pending);
    else passed++;
    total++;
    if (dmem_err !== 1'b0) $display("FAIL rst_mid_err: got %b want 0", dmem_err);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_mem[32'h80] = 32'h0000_A5A5;  // posted store was lost
    total++;
    if (dut.u_array.mem[32] !== 32'h0000_A5A5) $display("FAIL rst_mid_array: got %h want a5a5", dut.u_array.mem[32]);
    else passed++;
    do_op(2'd1, 32'h80, 32'h0, "rst_ld80");
  endtask

`ifdef DMEM_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    do_op(2'd1, 32'h100, 32'h0, "st_ld1");
    do_op(2'd1, 32'h40, 32'h0, "st_ld2");
    do_op(2'd2, 32'h70, 32'h1, "st_st1");
    do_op(2'd1, 32'h103, 32'h0, "st_err");
    do_op(2'd2, 32'h74, 32'h2, "st_st2");
    do_op(2'd1, 32'h44, 32'h0, "st_ld3");
    total++;
    if (ld_count !== 32'd3) $display("FAIL stats_ld: got %0d want 3", ld_count);
    else passed++;
    total++;
    if (st_count !== 32'd2) $display("FAIL stats_st: got %0d want 2", st_count);
    else passed++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_preload_load();
    test_store_forward();
    test_back_to_back();
    test_dbg_rules();
    test_errors();
    test_reset_mid();
`ifdef DMEM_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, giving the number of 32-bit words in data memory (power of two, 16..65536).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte address of word 0.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port proc2Dmem_command, input, 2 bits: bus command, encoded BUS_NONE=0, BUS_LOAD=1, BUS_STORE=2; value 3 is illegal.
REQ-006 SHALL have port proc2Dmem_addr, input, 32 bits: byte address.
REQ-007 SHALL have port proc2Dmem_data, input, 32 bits: store data.
REQ-008 SHALL have port mem2proc_data, output, 32 bits: load data.
REQ-009 SHALL have port dbg_wr_en, input, 1 bit: bench preload write strobe.
REQ-010 SHALL have port dbg_addr, input, 32 bits: preload byte address.
REQ-011 SHALL have port dbg_wdata, input, 32 bits: preload data.
REQ-012 SHALL have port wbuf_pending, output, 1 bit: the posted-write buffer holds an uncommitted store.
REQ-013 SHALL have port dmem_err, output, 1 bit: sticky error flag.

Function
REQ-014 SHALL return load data combinationally in the same cycle as BUS_LOAD, with zero wait states, because the pipeline consumes it in MEM.
REQ-015 SHALL post each BUS_STORE into a 1-entry write buffer (valid, word address, data) at the rising edge.
REQ-016 SHALL commit a valid buffer entry to the array on any edge with no dbg write; a new store arriving on the same edge replaces the committed entry.
REQ-017 SHALL coalesce a store to the buffered word address by overwriting the buffer data, with no array write on that edge.
REQ-018 SHALL forward buffer data on mem2proc_data when a load hits the buffered word address; otherwise it SHALL return the array word.
REQ-019 SHALL give dbg writes priority over buffer commit on the array port; the buffer holds its entry that cycle.
REQ-020 SHALL also update the buffer data if a dbg write hits the buffered address.
REQ-021 SHALL treat an access as an error if addr[1:0]!=0, the address is outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS), or the command is 3.
REQ-022 SHALL drive mem2proc_data to 0 on an erroneous access, drop an erroneous store, and set dmem_err on that edge.
REQ-023 SHALL drive mem2proc_data to 0 when the command is BUS_NONE or BUS_STORE.
REQ-024 SHALL apply the address-range and alignment rules to dbg writes as well; an out-of-range dbg write is ignored and does not set dmem_err.

Reset
REQ-025 SHALL, while rst is high, clear wbuf_pending, clear dmem_err, drive mem2proc_data to 0, and clear the counters.
REQ-026 SHALL discard a buffered store on reset (reset mid-operation loses it); array contents are not reset.

Configuration
REQ-027 SHALL, with DMEM_STATS_EN defined, add outputs ld_count[31:0] and st_count[31:0], which increment on each non-error load and store respectively, saturate at 32'hFFFF_FFFF, and are reset to 0.
REQ-028 SHALL, without DMEM_STATS_EN, omit these ports and counters; all other behaviour is identical.

Structure
REQ-029 SHALL place the bus command enum (BUS_NONE/LOAD/STORE) and the 32-bit word typedef in shared package dmem_pkg.
REQ-030 SHALL instantiate one sub-module, dmem_array: DEPTH_WORDS x 32 storage with one asynchronous read port and one synchronous write port.

Verification
REQ-031 SHALL cover: dbg preload 0x100=0xDEADBEEF, then LOAD 0x100 -> mem2proc_data=0xDEADBEEF in the same cycle.
REQ-032 SHALL cover: STORE 0x40=0x12345678, then LOAD 0x40 next cycle -> 0x12345678 forwarded with wbuf_pending=1; array holds the value after one more idle edge.
REQ-033 SHALL cover: back-to-back STORE 0x40=1 then 0x40=2, then LOAD 0x40 -> 2; STORE 0x44=3 commits 0x40=2 to the array.
REQ-034 SHALL cover: LOAD 0x102 (misaligned) and STORE 4*DEPTH_WORDS -> mem2proc_data=0, dmem_err=1 and held, array unchanged.
REQ-035 SHALL cover: STORE 0x80=5, then rst asserted before commit -> wbuf_pending=0, dmem_err=0, and LOAD 0x80 returns the old array value.
REQ-036 SHALL cover, with DMEM_STATS_EN: 3 loads, 2 stores, 1 error -> ld_count=3, st_count=2.
